and_unit_rr_arbiter: RTL and testbench
======================================

// Module: and_unit_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares a single WIDTH-bit bitwise AND
//   datapath among N_REQ requesters. Grants one requester at a time, latches its
//   operands, registers the AND result and returns it with a one-cycle done pulse.
//   Sits between several client blocks and the shared AND gate array.
// PARAMETERS
//   N_REQ  4  number of requesters (>=2); ptr width = clog2(N_REQ)
//   WIDTH  8  operand/result width in bits
// PORTS
//   clk     in   1            rising-edge clock
//   rst     in   1            synchronous reset, active-high
//   req     in   N_REQ        per-requester request, level
//   a_in    in   N_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
//   b_in    in   N_REQ*WIDTH  operand B; same packing
//   gnt     out  N_REQ        one-hot grant, registered
//   result  out  WIDTH        registered op_a & op_b of granted requester
//   done    out  1            1-cycle pulse, result valid for gnt owner
//   busy    out  1            high when state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, gnt=0, done=0, result=0, ptr=0, op_a=op_b=0; busy=0.
//   rst overrides everything; reset mid-transaction aborts it, no done pulse.
//   States: IDLE -> EXEC -> DONE -> IDLE; no other transitions.
//   IDLE: if req==0 stay. Else sel = first i with req[i]=1, searching
//     ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 (wrap). At edge: gnt<=onehot(sel),
//     op_a<=a_in[sel], op_b<=b_in[sel], state<=EXEC.
//   EXEC: at edge: result<=op_a&op_b, done<=1, state<=DONE.
//   DONE: done=1, result valid, gnt still asserted. At edge: gnt<=0, done<=0,
//     ptr<=(sel==N_REQ-1)?0:sel+1, state<=IDLE.
//   Latency: req seen in IDLE cycle n -> gnt from n+1, done+result in n+2.
//   Throughput: one operation per 3 cycles; next grant earliest n+4.
//   Operands captured only in IDLE->EXEC; later a_in/b_in changes ignored.
//   req deassert after grant ignored; transaction completes, done still pulses.
//   Requester must hold req until it sees gnt; its operands valid while req high.
//   result holds last value between done pulses (not cleared on IDLE).
//   gnt is always zero or one-hot; never changes during EXEC/DONE.
//   ptr changes only on DONE exit or reset; unchanged when idle with no req.
//   busy is combinational from the state register.
// TESTING
//   1 Hold rst 2 cycles, req=1111 -> gnt=0, done=0, result=0, busy=0 throughout.
//   2 req=0010, a1=8'hF0, b1=8'h3C in IDLE cycle n -> gnt=0010 cycles n+1..n+2,
//     done=1 only in n+2, result=8'h30; gnt=0 and busy=0 in n+3.
//   3 req=1111 held, distinct operands -> grants 0001,0010,0100,1000,0001 spaced
//     3 cycles apart; each result equals that requester's a&b.
//   4 After grant to requester 2 completes, req=0101 -> next gnt=0001 (ptr=3
//     wraps to 0); then req=0100 -> gnt=0100.
//   5 rst asserted during EXEC -> next cycle gnt=0, done=0, busy=0, no done pulse;
//     then req=1001 -> gnt=0001 (ptr reset to 0).
//   6 req=0001, a0=8'hFF,b0=8'h0F; during EXEC drop req, set a0=8'h00 -> done
//     still pulses with result=8'h0F.

Source files
------------

// File: rtl/and_unit_rr_arbiter.sv
`default_nettype none
// ============================================================================
// and_unit_rr_arbiter: round-robin sequencer sharing one WIDTH-bit AND datapath
// Rev 1.0
// ============================================================================
module and_unit_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         result,
  output logic                     done,
  output logic                     busy
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   sel_q;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;

  logic [N_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]   sel;
  logic               found;
  logic [N_REQ-1:0]   gnt_next;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  int                 pos;

  // Rotating req so that bit 0 corresponds to ptr turns the wrap search into
  // a plain lowest-set-bit scan.
  assign req_rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = int'(ptr) + k;
        if (pos >= N_REQ) pos = pos - N_REQ;
        sel   = PTR_W'(pos);
      end
    end
  end

  always_comb begin
    gnt_next = '0;
    a_sel    = '0;
    b_sel    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel == PTR_W'(k)) begin
        gnt_next[k] = 1'b1;
        a_sel       = a_in[k*WIDTH +: WIDTH];
        b_sel       = b_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= 1'b0;
      result <= '0;
      ptr    <= '0;
      sel_q  <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= gnt_next;
            op_a  <= a_sel;
            op_b  <= b_sel;
            sel_q <= sel;
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= op_a & op_b;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          gnt   <= '0;
          done  <= 1'b0;
          ptr   <= (sel_q == PTR_W'(N_REQ-1)) ? '0 : sel_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_and_unit_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_and_unit_rr_arbiter: directed and randomized checks against a reference model
// Rev 1.0
// ============================================================================
module tb_and_unit_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic [W-1:0]     result;
  logic             done;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction phase (0 idle, 1 granted, 2 result out).
  int           m_phase;
  int           m_ptr;
  int           m_owner;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_result;

  and_unit_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_phase  = 0;
      m_ptr    = 0;
      m_result = '0;
    end else if (m_phase == 0) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_a     = a_in[m_owner*W +: W];
        m_b     = b_in[m_owner*W +: W];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_result = m_a & m_b;
      m_phase  = 2;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_phase = 0;
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_gnt;
    exp_gnt = '0;
    if (m_phase != 0) exp_gnt[m_owner] = 1'b1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("done", 32'(done), 32'(m_phase == 2));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("result", 32'(result), 32'(m_result));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    m_phase = 0; m_ptr = 0; m_owner = 0; m_a = '0; m_b = '0; m_result = '0;
    rst  = 1'b1;
    req  = 4'b1111;
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));

    // Reset with requests pending: nothing may be granted.
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);

    rst = 1'b0;
    req = '0;
    tick();

    // All requesters active: rotation 0,1,2,3,0, three cycles apart.
    req = 4'b1111;
    set_op(0, 8'hA5, 8'h5F);
    set_op(1, 8'hC3, 8'hF0);
    set_op(2, 8'h7E, 8'h3C);
    set_op(3, 8'h99, 8'hFF);
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] oh;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      oh = '0;
      oh[g % N] = 1'b1;
      ea = a_in[(g % N)*W +: W];
      eb = b_in[(g % N)*W +: W];
      tick();
      check("rr_gnt", 32'(gnt), 32'(oh));
      tick();
      check("rr_result", 32'(result), 32'(ea & eb));
      tick();
    end
    req = '0;
    tick();

    // Single request latency.
    req = 4'b0010;
    set_op(1, 8'hF0, 8'h3C);
    tick();
    check("lat_gnt_n1", 32'(gnt), 32'b0010);
    check("lat_done_n1", 32'(done), 32'd0);
    req = '0;
    tick();
    check("lat_gnt_n2", 32'(gnt), 32'b0010);
    check("lat_done_n2", 32'(done), 32'd1);
    check("lat_result", 32'(result), 32'h30);
    tick();
    check("lat_gnt_n3", 32'(gnt), 32'd0);
    check("lat_busy_n3", 32'(busy), 32'd0);

    // Grant requester 2, then pointer wraps from 3 to 0.
    req = 4'b0100;
    tick(); req = '0; tick(); tick();
    req = 4'b0101;
    tick();
    check("wrap_gnt", 32'(gnt), 32'b0001);
    req = '0; tick(); tick();
    req = 4'b0100;
    tick();
    check("wrap_gnt2", 32'(gnt), 32'b0100);
    req = '0; tick(); tick();

    // Reset during EXEC aborts the transaction and clears the pointer.
    req = 4'b0010;
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_nodone", 32'(done), 32'd0);
    req = 4'b1001;
    tick();
    check("abort_gnt", 32'(gnt), 32'b0001);
    req = '0; tick(); tick();

    // Operand and req changes after the grant are ignored.
    req = 4'b0001;
    set_op(0, 8'hFF, 8'h0F);
    tick();
    req = '0;
    set_op(0, 8'h00, 8'h0F);
    tick();
    check("hold_done", 32'(done), 32'd1);
    check("hold_result", 32'(result), 32'h0F);
    tick();
    tick();
    check("hold_keep", 32'(result), 32'h0F);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
